valu: RTL and testbench



---
 rtl/valu.sv | 118 +++++++++++
 tb/tb_valu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/valu.sv
// valu: element-wise vector ALU for the vector execute stage.
// Applies one 4-bit op to ELEMENTS independent lanes of DATA_WIDTH bits.
// The result vector and its valid flag are registered, so latency is one cycle.
// Optional feature macro: VALU_MUL_EN. When it is defined, op 1100 returns the
// low half of the per-lane product. When it is undefined, no multiplier is
// built and op 1100 returns zero in every lane.
module valu #(
    parameter int DATA_WIDTH = 32,
    parameter int ELEMENTS   = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  valu_valid_in,
    input  logic [3:0]            valu_op_in,
    input  logic [DATA_WIDTH-1:0] vrs1_data_in [ELEMENTS],
    input  logic [DATA_WIDTH-1:0] vrs2_data_in [ELEMENTS],
    output logic [DATA_WIDTH-1:0] valu_res_o   [ELEMENTS],
    output logic                  valu_valid_o
);

    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_MIN  = 4'b1000;
    localparam logic [3:0] OP_MAX  = 4'b1001;
    localparam logic [3:0] OP_MINU = 4'b1010;
    localparam logic [3:0] OP_MAXU = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1110;

`ifdef VALU_MUL_EN
    // Low DATA_WIDTH bits of the product; the high half is never needed.
    function automatic logic [DATA_WIDTH-1:0] mul_lo(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] p;
        p = a * b;
        return p;
    endfunction
`endif

    // One lane of the ALU. Lanes never interact, so this is replicated per lane.
    function automatic logic [DATA_WIDTH-1:0] lane_op(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] a_s;
        logic signed [DATA_WIDTH-1:0] b_s;
        logic        [SHW-1:0]        sh;
        logic        [DATA_WIDTH-1:0] r;
        a_s = $signed(a);
        b_s = $signed(b);
        // Only the low log2(DATA_WIDTH) bits of b select the shift distance.
        sh  = b[SHW-1:0];
        r   = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $unsigned(a_s >>> sh);
            OP_MIN:  r = (a_s < b_s) ? a : b;
            OP_MAX:  r = (a_s < b_s) ? b : a;
            OP_MINU: r = (a < b) ? a : b;
            OP_MAXU: r = (a < b) ? b : a;
`ifdef VALU_MUL_EN
            OP_MUL:  r = mul_lo(a, b);
`else
            OP_MUL:  r = '0;
`endif
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default: r = a;  // MV
        endcase
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] res_p0 [ELEMENTS];
    logic [DATA_WIDTH-1:0] res_p1 [ELEMENTS];
    logic                  vld_p1;

    // Stage p0: combinational per-lane result from the live operands.
    always_comb begin
        for (int i = 0; i < ELEMENTS; i++) begin
            res_p0[i] = lane_op(valu_op_in, vrs1_data_in[i], vrs2_data_in[i]);
        end
    end

    // Stage p1: capture result on a valid request; hold it otherwise.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_p1 <= '{default: '0};
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= valu_valid_in;
            if (valu_valid_in) begin
                res_p1 <= res_p0;
            end
        end
    end

    assign valu_res_o   = res_p1;
    assign valu_valid_o = vld_p1;

endmodule

// File: tb/tb_valu.sv
// tb_valu: directed and random stimulus for valu with a scoreboard queue.
module tb_valu;

    localparam int DW = 32;
    localparam int EL = 8;

    typedef logic [EL-1:0][DW-1:0] pvec_t;

    logic          clk;
    logic          rst_n;
    logic          vld_in;
    logic [3:0]    op;
    logic [DW-1:0] a_arr   [EL];
    logic [DW-1:0] b_arr   [EL];
    logic [DW-1:0] res_arr [EL];
    logic          vld_out;
    pvec_t         res_pk;

    int    checks = 0;
    int    errors = 0;
    pvec_t exp_q[$];
    pvec_t last_exp;

    valu #(.DATA_WIDTH(DW), .ELEMENTS(EL)) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .valu_valid_in(vld_in),
        .valu_op_in   (op),
        .vrs1_data_in (a_arr),
        .vrs2_data_in (b_arr),
        .valu_res_o   (res_arr),
        .valu_valid_o (vld_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < EL; i++) res_pk[i] = res_arr[i];
    end

    // Independent reference for one lane.
    function automatic logic [DW-1:0] ref_lane(input logic [3:0] o,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [4:0]    sh;
        logic [DW-1:0] r;
        logic [63:0]   p;
        logic          slt;
        sh  = b[4:0];
        slt = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        p   = {32'b0, a} * {32'b0, b};
        case (o)
            4'd0:  r = a + b;
            4'd1:  r = a + ~b + 32'd1;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8:  r = slt ? a : b;
            4'd9:  r = slt ? b : a;
            4'd10: r = (a < b) ? a : b;
            4'd11: r = (a < b) ? b : a;
`ifdef VALU_MUL_EN
            4'd12: r = p[31:0];
`else
            4'd12: r = 32'h0;
`endif
            4'd13: r = {31'b0, slt};
            4'd14: r = {31'b0, (a < b)};
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic pvec_t bc(input logic [DW-1:0] x);
        pvec_t v;
        for (int i = 0; i < EL; i++) v[i] = x;
        return v;
    endfunction

    task automatic chk_vec(input string tag, input pvec_t obs, input pvec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one request at the falling edge, push expectation, check after next rise.
    task automatic issue(input string tag, input logic [3:0] o,
                         input pvec_t a, input pvec_t b, input pvec_t exp);
        pvec_t e;
        op     = o;
        vld_in = 1'b1;
        for (int i = 0; i < EL; i++) begin
            a_arr[i] = a[i];
            b_arr[i] = b[i];
        end
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_vec(tag, res_pk, e);
            last_exp = e;
        end
        chk_bit({tag, "_vld"}, vld_out, 1'b1);
    endtask

    task automatic issue_model(input string tag, input logic [3:0] o,
                               input pvec_t a, input pvec_t b);
        pvec_t e;
        for (int i = 0; i < EL; i++) e[i] = ref_lane(o, a[i], b[i]);
        issue(tag, o, a, b, e);
    endtask

    initial begin
        pvec_t va, vb, ve;
        rst_n    = 1'b0;
        vld_in   = 1'b0;
        op       = 4'd0;
        last_exp = '0;
        for (int i = 0; i < EL; i++) begin
            a_arr[i] = 32'hA5A5_0000 + i;
            b_arr[i] = 32'h0000_5A5A + i;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk_vec("reset_res", res_pk, '0);
        chk_bit("reset_vld", vld_out, 1'b0);
        rst_n = 1'b1;

        // ADD on lanes {1..8}
        for (int i = 0; i < EL; i++) begin
            va[i] = i + 1;
            ve[i] = 2 * (i + 1);
        end
        issue("add_seq", 4'b0000, va, va, ve);

        // Wrap and subtract
        issue("add_wrap", 4'b0000, bc(32'hFFFF_FFFF), bc(32'd1), bc(32'h0));
        issue("sub_wrap", 4'b0001, bc(32'h0), bc(32'd1), bc(32'hFFFF_FFFF));

        // Shifts: upper bits of b ignored (0x21 -> 1)
        issue("sll", 4'b0101, bc(32'h8000_0000), bc(32'h21), bc(32'h0));
        issue("srl", 4'b0110, bc(32'h8000_0000), bc(32'h21), bc(32'h4000_0000));
        issue("sra", 4'b0111, bc(32'h8000_0000), bc(32'h21), bc(32'hC000_0000));

        // Signed vs unsigned
        issue("min",  4'b1000, bc(32'hFFFF_FFFF), bc(32'd1), bc(32'hFFFF_FFFF));
        issue("minu", 4'b1010, bc(32'hFFFF_FFFF), bc(32'd1), bc(32'd1));
        issue("slt",  4'b1101, bc(32'hFFFF_FFFF), bc(32'd1), bc(32'd1));
        issue("sltu", 4'b1110, bc(32'hFFFF_FFFF), bc(32'd1), bc(32'd0));

        // Multiply, result depends on build option
`ifdef VALU_MUL_EN
        issue("mul", 4'b1100, bc(32'd3), bc(32'd7), bc(32'd21));
`else
        issue("mul", 4'b1100, bc(32'd3), bc(32'd7), bc(32'd0));
`endif

        // Drop valid with new operands: result must hold
        vld_in = 1'b0;
        op     = 4'b0000;
        for (int i = 0; i < EL; i++) begin
            a_arr[i] = 32'h1111_1111;
            b_arr[i] = 32'h2222_2222;
        end
        @(posedge clk);
        @(negedge clk);
        chk_bit("hold_vld", vld_out, 1'b0);
        chk_vec("hold_res", res_pk, last_exp);

        // Random lanes for every op; lane 0 uses a==b
        for (int o = 0; o < 16; o++) begin
            for (int rep = 0; rep < 2; rep++) begin
                for (int i = 0; i < EL; i++) begin
                    va[i] = $urandom;
                    vb[i] = (i == 0) ? va[i] : $urandom;
                end
                issue_model($sformatf("rand_op%0d_%0d", o, rep), o[3:0], va, vb);
            end
        end

        // Asynchronous reset between edges while valid_o is high
        issue("pre_rst", 4'b1111, bc(32'hDEAD_BEEF), bc(32'h0), bc(32'hDEAD_BEEF));
        #2;
        rst_n = 1'b0;
        #1;
        chk_vec("async_rst_res", res_pk, '0);
        chk_bit("async_rst_vld", vld_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst", 4'b0100, bc(32'hF0F0_F0F0), bc(32'hFF00_FF00), bc(32'h0FF0_0FF0));

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
